// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: opcode encodings
// and default width constants.
package pc_sequencer_pkg;

  localparam int DEF_PC_WIDTH       = 8;
  localparam int DEF_VALUE_WIDTH    = 8;
  localparam int DEF_REGISTER_WIDTH = 8;
  localparam int DEF_OPCODE_WIDTH   = 4;
  localparam int DEF_STACK_DEPTH    = 16;

  // Encodings not listed here fall through to "advance by one".
  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_RET     = 4'd1,
    OP_CALL    = 4'd2,
    OP_JMP     = 4'd3,
    OP_IF0JUMP = 4'd4,
    OP_IF1JUMP = 4'd5,
    OP_RST     = 4'd6
  } opcode_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return stack: LIFO array, depth count, optional guard logic.
// Guard logic is built only when PC_STACK_GUARD_EN is defined; without it
// the write index wraps onto entry 0 and an empty pop reads the top entry.
module return_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 16,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] pushData,
  output logic [PC_WIDTH-1:0] popData,
  output logic [SP_WIDTH-1:0] depth,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_WIDTH-1:0] DEPTH_MAX = SP_WIDTH'(STACK_DEPTH);
  localparam logic [IDX_W-1:0]    IDX_TOP   = IDX_W'(STACK_DEPTH - 1);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [SP_WIDTH-1:0] depth_q;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic                write_en;

  assign depth = depth_q;
  assign full  = (depth_q == DEPTH_MAX);
  assign empty = (depth_q == '0);

  // Index decode handles non-power-of-two depths: full wraps to 0, empty reads the top slot.
  always_comb begin
    wr_idx = full  ? '0      : IDX_W'(depth_q);
    rd_idx = empty ? IDX_TOP : IDX_W'(depth_q - SP_WIDTH'(1));
  end

`ifdef PC_STACK_GUARD_EN
  assign write_en = push && !flush && !full;
  assign popData  = empty ? '0 : mem[rd_idx];

  // Sticky error flags; only a real reset clears them, a flush does not.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)  overflow  <= 1'b1;
      if (pop  && empty) underflow <= 1'b1;
    end
  end
`else
  assign write_en  = push && !flush;
  assign popData   = mem[rd_idx];
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // Stack storage is not reset; contents are meaningless until pushed.
  always_ff @(posedge clock) begin
    if (!reset && write_en) mem[wr_idx] <= pushData;
  end

  // Depth count saturates at both ends in every build.
  always_ff @(posedge clock) begin
    if (reset || flush)       depth_q <= '0;
    else if (push && !full)   depth_q <= depth_q + SP_WIDTH'(1);
    else if (pop  && !empty)  depth_q <= depth_q - SP_WIDTH'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with integrated return stack.
// Optional build macro PC_STACK_GUARD_EN enables overflow/underflow guarding.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH       = DEF_PC_WIDTH,
  parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int OPCODE_WIDTH   = DEF_OPCODE_WIDTH,
  parameter int STACK_DEPTH    = DEF_STACK_DEPTH,
  parameter int SP_WIDTH       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [OPCODE_WIDTH-1:0]   opcode,
  input  logic [VALUE_WIDTH-1:0]    instructionValue,
  input  logic [REGISTER_WIDTH-1:0] registerValue,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [SP_WIDTH-1:0]       stackDepth,
  output logic                      stackEmpty,
  output logic                      stackFull,
  output logic                      overflow,
  output logic                      underflow
);

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_plus_one;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] pop_data;
  logic                do_push;
  logic                do_pop;
  logic                do_flush;

  // Size cast truncates a wider immediate and zero-extends a narrower one.
  assign target      = PC_WIDTH'(instructionValue);
  assign pc_plus_one = pc + PC_WIDTH'(1);

  // Next-pc mux and stack control; a stall freezes everything.
  always_comb begin
    next_pc  = pc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_flush = 1'b0;
    if (!stall) begin
      case (opcode)
        OPCODE_WIDTH'(OP_JMP):     next_pc = target;
        OPCODE_WIDTH'(OP_CALL): begin
          next_pc = target;
          do_push = 1'b1;
        end
        OPCODE_WIDTH'(OP_RET): begin
          next_pc = pop_data;
          do_pop  = 1'b1;
        end
        OPCODE_WIDTH'(OP_IF0JUMP): next_pc = (registerValue == '0) ? target : pc_plus_one;
        OPCODE_WIDTH'(OP_IF1JUMP): next_pc = (registerValue != '0) ? target : pc_plus_one;
        OPCODE_WIDTH'(OP_RST): begin
          next_pc  = '0;
          do_flush = 1'b1;
        end
        default:                   next_pc = pc_plus_one;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clock) begin
    if (reset) pc <= '0;
    else       pc <= next_pc;
  end

  return_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .SP_WIDTH    (SP_WIDTH)
  ) u_return_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (do_flush),
    .pushData  (pc_plus_one),
    .popData   (pop_data),
    .depth     (stackDepth),
    .full      (stackFull),
    .empty     (stackEmpty),
    .overflow  (overflow),
    .underflow (underflow)
  );

endmodule
